// File: rtl/result_deskewer.sv
// result_deskewer: re-aligns column-skewed systolic array outputs into
// whole rows, buffers them in a FIFO and tracks frame completion.
module result_deskewer #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] sum_in,
  input  logic                                  sum_valid,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] out_row,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  frame_done,
  output logic                                  overflow,
  output logic                                  busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(MATRIX_SIZE + FIFO_DEPTH + 2) + 1;
  localparam logic [CW-1:0] NR = CW'(MATRIX_SIZE);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } state_t;

  row_t aligned;
  logic push;

  for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
    localparam int D = MATRIX_SIZE - 1 - j;
    if (D == 0) begin : g_thru
      assign aligned[j] = sum_in[j];
    end else begin : g_dly
      logic [DATA_SIZE-1:0] dl [D];
      // Delay column j so it lines up with the last column
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < D; k++) dl[k] <= '0;
        end else begin
          dl[0] <= sum_in[j];
          for (int k = 1; k < D; k++) dl[k] <= dl[k-1];
        end
      end
      assign aligned[j] = dl[D-1];
    end
  end

  if (MATRIX_SIZE == 1) begin : g_vnone
    assign push = sum_valid;
  end else begin : g_vsr
    logic [MATRIX_SIZE-2:0] vsr;
    // Row strobe travels alongside column 0
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vsr <= '0;
      end else begin
        vsr[0] <= sum_valid;
        for (int k = 1; k < MATRIX_SIZE - 1; k++) vsr[k] <= vsr[k-1];
      end
    end
    assign push = vsr[MATRIX_SIZE-2];
  end

  row_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          wr;
  logic          drop;

  assign full      = (count == FULL);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign wr        = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign out_row   = out_valid ? mem[rptr] : '0;

  // Row storage; head is read directly, so no reset needed
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= aligned;
  end

  // Pointers, occupancy and sticky drop flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (wr && !pop)      count <= count + 1'b1;
      else if (!wr && pop) count <= count - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] rows_in;
  logic [CW-1:0] rows_out;
  logic [CW-1:0] rows_in_n;
  logic [CW-1:0] rows_out_n;
  logic [CW-1:0] rin_inc;
  logic [CW-1:0] rout_inc;

  assign rin_inc  = rows_in + CW'(wr);
  assign rout_inc = rows_out + CW'(pop);
  assign busy     = (state != IDLE);

  // Frame state and row counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rows_in  <= '0;
      rows_out <= '0;
    end else begin
      state    <= state_n;
      rows_in  <= rows_in_n;
      rows_out <= rows_out_n;
    end
  end

  // Rows beyond a complete frame carry into the next frame's counts
  always_comb begin
    state_n    = state;
    rows_in_n  = rin_inc;
    rows_out_n = rout_inc;
    frame_done = 1'b0;
    unique case (state)
      IDLE, COLLECT: begin
        if (rin_inc >= NR) begin
          rows_in_n = rin_inc - NR;
          if (rout_inc >= NR) begin
            state_n    = DONE;
            rows_out_n = rout_inc - NR;
          end else begin
            state_n = DRAIN;
          end
        end else if (rin_inc != '0) begin
          state_n = COLLECT;
        end
      end
      DRAIN: begin
        if (rout_inc >= NR) begin
          state_n    = DONE;
          rows_out_n = rout_inc - NR;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_deskewer.sv
// tb_result_deskewer: directed stimulus with a queue scoreboard and
// a negedge monitor for rows and frame_done pulses.
module tb_result_deskewer;

  localparam int N = 2;
  localparam int W = 32;
  localparam int D = 4;

  typedef logic [N-1:0][W-1:0] row_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sum_valid = 1'b0;
  logic out_ready = 1'b0;
  row_t sum_in = '0;
  row_t out_row;
  logic out_valid;
  logic frame_done;
  logic overflow;
  logic busy;

  int   tests = 0;
  int   fails = 0;
  row_t exp_q[$];
  int   xfers = 0;
  int   fd_count = 0;
  bit   prev_pop = 1'b0;
  bit   keep = 1'b1;
  logic [W-1:0] ra [16];
  logic [W-1:0] rb [16];

  always #5 clk = ~clk;

  result_deskewer #(
    .MATRIX_SIZE(N),
    .DATA_SIZE(W),
    .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sum_in(sum_in),
    .sum_valid(sum_valid),
    .out_row(out_row),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_done(frame_done),
    .overflow(overflow),
    .busy(busy)
  );

  always @(negedge clk) begin : mon
    row_t e;
    if (!reset) begin
      xfers = 0;
      fd_count = 0;
      prev_pop = 1'b0;
    end else begin
      if (frame_done) begin
        fd_count++;
        tests++;
        if (!prev_pop || (xfers % N) != 0) begin
          fails++;
          $display("FAIL frame_done_timing: prev_xfer=%0d xfers=%0d, required prev_xfer=1 and xfers multiple of %0d",
                   prev_pop, xfers, N);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got row %h, required no row", out_row);
        end else begin
          e = exp_q.pop_front();
          if (out_row !== e) begin
            fails++;
            $display("FAIL sb_row: got %h, required %h", out_row, e);
          end
        end
        xfers++;
      end
      prev_pop = out_valid && out_ready;
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input int n, input int rdy_at);
    for (int i = 0; i <= n; i++) begin
      if (i == rdy_at) out_ready = 1'b1;
      sum_valid = (i < n);
      sum_in[0] = (i < n) ? ra[i] : '0;
      sum_in[1] = (i > 0) ? rb[i-1] : '0;
      if (i < n && keep) exp_q.push_back({rb[i], ra[i]});
      tick();
    end
    sum_valid = 1'b0;
    sum_in = '0;
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sum_valid = 1'b0;
    sum_in = '0;
    out_ready = 1'b0;
    keep = 1'b1;
    repeat (2) tick();
    exp_q.delete();
    reset = 1'b1;
    tick();
  endtask

  task automatic single_row(input string tag, input logic [W-1:0] a,
                            input logic [W-1:0] b);
    row_t r;
    r = {b, a};
    out_ready = 1'b1;
    sum_valid = 1'b1;
    sum_in[0] = a;
    exp_q.push_back(r);
    tick();
    check({tag, "_c1_valid"}, 64'(out_valid), 64'd0);
    sum_valid = 1'b0;
    sum_in[0] = '0;
    sum_in[1] = b;
    tick();
    check({tag, "_c2_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_c2_row"}, out_row, r);
    sum_in = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    #2 reset = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_out_row", out_row, 64'd0);
    do_reset();

    single_row("lat", 32'd5, 32'd7);
    wait_drain(10);

    do_reset();
    out_ready = 1'b1;
    ra[0] = 32'd5;  rb[0] = 32'd7;
    ra[1] = 32'd11; rb[1] = 32'd13;
    burst(2, 99);
    check("b2b_c3_fd", 64'(frame_done), 64'd0);
    check("b2b_c3_busy", 64'(busy), 64'd1);
    tick();
    check("b2b_c4_fd", 64'(frame_done), 64'd1);
    tick();
    check("b2b_c5_fd", 64'(frame_done), 64'd0);
    check("b2b_c5_busy", 64'(busy), 64'd0);
    check("b2b_fd_count", 64'(fd_count), 64'd1);
    check("b2b_q_empty", 64'(exp_q.size()), 64'd0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      ra[i] = 32'h100 + 32'(i);
      rb[i] = 32'h200 + 32'(i);
    end
    burst(4, 99);
    check("ovf_full_none", 64'(overflow), 64'd0);
    check("ovf_full_valid", 64'(out_valid), 64'd1);
    check("ovf_head", out_row, {32'h200, 32'h100});
    tick();
    tick();
    check("ovf_head_stable", out_row, {32'h200, 32'h100});
    keep = 1'b0;
    ra[0] = 32'h555;
    rb[0] = 32'h666;
    burst(1, 99);
    keep = 1'b1;
    tick();
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_head_kept", out_row, {32'h200, 32'h100});
    out_ready = 1'b1;
    wait_drain(20);
    repeat (4) tick();
    check("ovf_fd_count", 64'(fd_count), 64'd2);
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("ovf_idle", 64'(busy), 64'd0);
    check("ovf_empty", 64'(out_valid), 64'd0);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      ra[i] = 32'hA0 + 32'(i);
      rb[i] = 32'hB0 + 32'(i);
    end
    burst(5, 5);
    wait_drain(20);
    check("pp_no_overflow", 64'(overflow), 64'd0);

    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ra[i] = 32'h1000 + 32'(i);
      rb[i] = 32'h2000 + 32'(i);
    end
    burst(4, 99);
    wait_drain(20);
    repeat (3) tick();
    check("two_frames_fd", 64'(fd_count), 64'd2);
    check("two_frames_idle", 64'(busy), 64'd0);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      ra[i] = 32'hC0 + 32'(i);
      rb[i] = 32'hD0 + 32'(i);
    end
    burst(5, 99);
    tick();
    check("mid_pre_overflow", 64'(overflow), 64'd1);
    check("mid_pre_busy", 64'(busy), 64'd1);
    check("mid_pre_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    check("mid_rst_row", out_row, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #2 reset = 1'b1;
    tick();
    single_row("post", 32'd1, 32'd2);
    wait_drain(10);
    check("post_overflow", 64'(overflow), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
